pump_sequencer: RTL and testbench

Parametrised power-on and data-pump start sequencer for the microcontroller/OSD data pump. After reset it holds a configurable power-on delay, then publishes a READY code on `pump_o` and arbitrates up to N_CH download-request channels. Each download is tracked to completion with an optional watchdog that reports an error code. It sits between the board reset/controller download strobes and the pump consumer logic, replacing the single-channel fixed-delay start signal.

---
 rtl/pump_pkg.sv | 28 ++
 rtl/pump_downcounter.sv | 36 +++
 rtl/pump_sequencer.sv | 155 +++++++++++++++
 tb/tb_pump_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pump_pkg.sv
// Shared types, default status codes and the channel priority helper
// for the pump start sequencer.
package pump_pkg;

  typedef enum logic [2:0] {
    ST_POWERON = 3'd0,
    ST_READY   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } pump_state_t;

  localparam logic [7:0] READY_CODE_DEF = 8'h3F;
  localparam logic [7:0] DONE_CODE_DEF  = 8'hFF;
  localparam logic [7:0] ERR_CODE_DEF   = 8'hE0;
  localparam logic [3:0] LOAD_PREFIX    = 4'h8;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pump_downcounter.sv
// Loadable down-counter that saturates at zero; used for the power-on
// delay and the download watchdog.
module pump_downcounter #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         enable_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= RST_VAL;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/pump_sequencer.sv
// Power-on delay, channel arbitration and download tracking for the data
// pump. All outputs come straight from registers.
module pump_sequencer
  import pump_pkg::*;
#(
  parameter int                   DELAY_W        = 16,
  parameter logic [DELAY_W-1:0]   DELAY_CYCLES   = '1,
  parameter int                   N_CH           = 2,
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = '1,
  parameter logic [7:0]           READY_CODE     = READY_CODE_DEF,
  parameter logic [7:0]           DONE_CODE      = DONE_CODE_DEF,
  parameter logic [7:0]           ERR_CODE       = ERR_CODE_DEF
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            rearm_i,
  input  logic [N_CH-1:0] download_i,
  output logic [7:0]      pump_o,
  output logic [3:0]      ch_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  pump_state_t state_q, state_d;
  logic [7:0] pump_q, pump_d;
  logic [3:0] ch_q, ch_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [DELAY_W-1:0]   delay_cnt;
  logic [TIMEOUT_W-1:0] wd_cnt, wd_value;
  logic delay_zero, wd_zero, wd_load, wd_enable;
  logic any_dl, ch_level, start, wd_expired, unused_cnt;
  logic [3:0] win;

  assign any_dl     = |download_i;
  assign win        = lowest_set(16'(download_i));
  assign ch_level   = |(download_i & (N_CH'(1) << ch_q));
  assign start      = ((state_q == ST_READY) || (state_q == ST_DONE)) && any_dl;
  assign wd_expired = (TIMEOUT_CYCLES != '0) && wd_zero;
  assign unused_cnt = ^{delay_cnt, wd_cnt};

  // Rearm reloads the delay and clears the watchdog back to its reset value.
  assign wd_load   = rearm_i || start;
  assign wd_value  = rearm_i ? '0 : TIMEOUT_CYCLES;
  assign wd_enable = (state_q == ST_LOAD) && ch_level;

  pump_downcounter #(.W(DELAY_W), .RST_VAL(DELAY_CYCLES)) u_delay (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (rearm_i),
    .value_i  (DELAY_CYCLES),
    .enable_i (state_q == ST_POWERON),
    .count_o  (delay_cnt),
    .zero_o   (delay_zero)
  );

  pump_downcounter #(.W(TIMEOUT_W), .RST_VAL('0)) u_watchdog (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (wd_load),
    .value_i  (wd_value),
    .enable_i (wd_enable),
    .count_o  (wd_cnt),
    .zero_o   (wd_zero)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_POWERON;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rearm_i) begin
      state_d = ST_POWERON;
    end else begin
      case (state_q)
        ST_POWERON: if (delay_zero) state_d = ST_READY;
        ST_READY,
        ST_DONE:    if (any_dl) state_d = ST_LOAD;
        ST_LOAD: begin
          if (!ch_level)       state_d = ST_DONE;
          else if (wd_expired) state_d = ST_ERROR;
        end
        default:    state_d = state_q;
      endcase
    end
  end

  // Channel fall is tested before watchdog expiry so a tie reports DONE.
  always_comb begin
    pump_d = pump_q;
    ch_d   = ch_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d  = err_q;
    if (rearm_i) begin
      pump_d = 8'h00;
      ch_d   = 4'h0;
      busy_d = 1'b0;
      done_d = 1'b0;
      err_d  = 1'b0;
    end else begin
      case (state_q)
        ST_POWERON: if (delay_zero) pump_d = READY_CODE;
        ST_READY,
        ST_DONE: begin
          if (any_dl) begin
            ch_d   = win;
            pump_d = {LOAD_PREFIX, win};
            busy_d = 1'b1;
            done_d = 1'b0;
          end
        end
        ST_LOAD: begin
          if (!ch_level) begin
            pump_d = DONE_CODE;
            done_d = 1'b1;
            busy_d = 1'b0;
          end else if (wd_expired) begin
            pump_d = ERR_CODE;
            err_d  = 1'b1;
            busy_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pump_q <= 8'h00;
      ch_q   <= 4'h0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pump_q <= pump_d;
      ch_q   <= ch_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign pump_o = pump_q;
  assign ch_o   = ch_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_pump_sequencer.sv
// Directed and randomized checks of pump_sequencer against a phase-level
// reference model (DELAY_CYCLES=4, TIMEOUT_CYCLES=8, N_CH=2).
module tb_pump_sequencer;

  localparam int DLY  = 4;
  localparam int TMO  = 8;
  localparam int NCH  = 2;

  localparam int PH_PON   = 0;
  localparam int PH_READY = 1;
  localparam int PH_LOAD  = 2;
  localparam int PH_DONE  = 3;
  localparam int PH_ERR   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rearm = 1'b0;
  logic [NCH-1:0] download = '0;
  logic [7:0]     pump;
  logic [3:0]     ch;
  logic           busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase plus edge counts since entering it.
  int         m_phase;
  int         m_pon_edges;
  int         m_load_edges;
  logic [3:0] m_ch;

  pump_sequencer #(
    .DELAY_W(16), .DELAY_CYCLES(16'd4), .N_CH(NCH),
    .TIMEOUT_W(24), .TIMEOUT_CYCLES(24'd8)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .rearm_i    (rearm),
    .download_i (download),
    .pump_o     (pump),
    .ch_o       (ch),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase      = PH_PON;
    m_pon_edges  = 0;
    m_load_edges = 0;
    m_ch         = 4'h0;
  endtask

  task automatic model_step(input logic [NCH-1:0] dl, input logic rw);
    if (rw) begin
      model_reset();
    end else begin
      case (m_phase)
        PH_PON: begin
          m_pon_edges++;
          if (m_pon_edges == DLY + 1) m_phase = PH_READY;
        end
        PH_READY, PH_DONE: begin
          if (dl != 0) begin
            for (int i = NCH - 1; i >= 0; i--) if (dl[i]) m_ch = 4'(i);
            m_phase      = PH_LOAD;
            m_load_edges = 0;
          end
        end
        PH_LOAD: begin
          m_load_edges++;
          if (!dl[m_ch])                      m_phase = PH_DONE;
          else if (m_load_edges == TMO + 1)   m_phase = PH_ERR;
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] e_pump;
    case (m_phase)
      PH_PON:   e_pump = 8'h00;
      PH_READY: e_pump = 8'h3F;
      PH_LOAD:  e_pump = {4'h8, m_ch};
      PH_DONE:  e_pump = 8'hFF;
      default:  e_pump = 8'hE0;
    endcase
    chk({tag, ".pump"}, pump, e_pump);
    chk({tag, ".ch"},   {4'h0, ch}, {4'h0, m_ch});
    chk({tag, ".busy"}, {7'h0, busy}, {7'h0, m_phase == PH_LOAD});
    chk({tag, ".done"}, {7'h0, done}, {7'h0, m_phase == PH_DONE});
    chk({tag, ".err"},  {7'h0, err},  {7'h0, m_phase == PH_ERR});
  endtask

  // Drive inputs, advance one edge, update the model, sample 1 time unit later.
  task automatic tick(input string tag, input logic [NCH-1:0] dl, input logic rw);
    download = dl;
    rearm    = rw;
    @(posedge clk);
    if (!rst) model_step(dl, rw);
    #1;
    check_model(tag);
  endtask

  initial begin
    int hold;
    logic [NCH-1:0] rdl;
    logic rrw;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b0;

    // Power-on: four edges at 00, READY after the fifth.
    for (int i = 0; i < DLY; i++) begin
      tick("pon", 2'b00, 1'b0);
      chk("pon_hold", pump, 8'h00);
    end
    tick("pon_end", 2'b00, 1'b0);
    chk("pon_ready", pump, 8'h3F);
    repeat (2) tick("ready_idle", 2'b00, 1'b0);

    // Normal load on channel 1 for three cycles.
    tick("load1", 2'b10, 1'b0);
    chk("load1_code", pump, 8'h81);
    chk("load1_ch", {4'h0, ch}, 8'h01);
    repeat (2) tick("load1_hold", 2'b10, 1'b0);
    tick("load1_fall", 2'b00, 1'b0);
    chk("load1_done", pump, 8'hFF);
    chk("load1_done_o", {7'h0, done}, 8'h01);

    // Arbitration from DONE: lowest index wins, other channel ignored.
    tick("arb", 2'b11, 1'b0);
    chk("arb_code", pump, 8'h80);
    tick("arb_drop1", 2'b01, 1'b0);
    chk("arb_drop1_code", pump, 8'h80);
    tick("arb_drop0", 2'b00, 1'b0);
    chk("arb_done", pump, 8'hFF);

    // Watchdog: error on the ninth edge in LOAD, sticky until rearm.
    tick("wd_enter", 2'b01, 1'b0);
    for (int i = 0; i < TMO; i++) tick("wd_hold", 2'b01, 1'b0);
    chk("wd_not_yet", pump, 8'h80);
    tick("wd_expire", 2'b01, 1'b0);
    chk("wd_err_code", pump, 8'hE0);
    chk("wd_err_o", {7'h0, err}, 8'h01);
    tick("err_sticky", 2'b10, 1'b0);
    tick("err_sticky", 2'b11, 1'b0);
    tick("rearm", 2'b00, 1'b1);
    chk("rearm_code", pump, 8'h00);
    for (int i = 0; i < DLY + 1; i++) tick("rearm_pon", 2'b00, 1'b0);
    chk("rearm_ready", pump, 8'h3F);

    // Tie: channel falls on the edge the watchdog would expire.
    tick("tie_enter", 2'b01, 1'b0);
    for (int i = 0; i < TMO; i++) tick("tie_hold", 2'b01, 1'b0);
    tick("tie_fall", 2'b00, 1'b0);
    chk("tie_code", pump, 8'hFF);
    chk("tie_err_o", {7'h0, err}, 8'h00);

    // Asynchronous reset while busy, then download held through power-on.
    tick("rst_enter", 2'b10, 1'b0);
    tick("rst_hold", 2'b10, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    chk("async_rst_busy", {7'h0, busy}, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < DLY; i++) tick("rst_pon", 2'b10, 1'b0);
    tick("rst_ready", 2'b10, 1'b0);
    chk("rst_ready_code", pump, 8'h3F);
    tick("rst_accept", 2'b10, 1'b0);
    chk("rst_accept_code", pump, 8'h81);

    // Randomized runs of held download patterns with occasional rearm.
    for (int n = 0; n < 60; n++) begin
      rdl  = NCH'($urandom_range(0, 3));
      hold = $urandom_range(1, 12);
      for (int k = 0; k < hold; k++) begin
        rrw = ($urandom_range(0, 39) == 0);
        tick("rand", rdl, rrw);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
